// File: rtl/complex_mac_pipe_pkg.sv
// complex_mac_pipe_pkg: opcode encodings and default widths for the complex MAC pipeline
package complex_mac_pipe_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS_DEF = 15;
  localparam int ACC_WIDTH_DEF = 48;
  localparam int LEN_WIDTH_DEF = 8;
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_CMULT = 3'b100;
  localparam logic [2:0] OP_MULADD = 3'b101;
  localparam logic [2:0] OP_MULSUB = 3'b110;
  localparam logic [2:0] OP_CMAC = 3'b111;
endpackage

// File: rtl/cplx_round_sat.sv
// cplx_round_sat: round-half-up then saturate a wide signed fixed-point value to OUT_W bits
module cplx_round_sat
  import complex_mac_pipe_pkg::*;
#(
  parameter int IN_W = ACC_WIDTH_DEF,
  parameter int OUT_W = DATA_WIDTH_DEF,
  parameter int FRAC = FRAC_BITS_DEF
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (FRAC-1);
  localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [IN_W:0] sh;
  logic hi, lo;
  assign sh = ((IN_W+1)'(din) + HALF) >>> FRAC;
  assign hi = sh > MAXV;
  assign lo = sh < MINV;
  assign sat = hi | lo;
  assign dout = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : sh[OUT_W-1:0];
endmodule

// File: rtl/complex_mac_pipe.sv
// complex_mac_pipe: 4-stage complex multiply / multiply-add / accumulate unit with valid-ready stall
module complex_mac_pipe
  import complex_mac_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              opcode,
  input  logic [LEN_WIDTH-1:0]    acc_len,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [2*DATA_WIDTH-1:0] din_1,
  input  logic [2*DATA_WIDTH-1:0] din_2,
  input  logic [2*DATA_WIDTH-1:0] din_3,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [2*DATA_WIDTH-1:0] dout,
  output logic                    sat_flag,
  input  logic                    sat_clr
);
  localparam int CW = 2*DATA_WIDTH;
  typedef logic signed [DATA_WIDTH-1:0] d_t;
  typedef logic signed [CW-1:0] p_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  localparam acc_t AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam acc_t AMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic ce;
  assign ce = !(dout_valid && !dout_ready);
  assign din_ready = ce && !rst;
  logic v1;
  logic [2:0] op1;
  logic [LEN_WIDTH-1:0] len1;
  logic [CW-1:0] x1, y1, w1;
  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else if (ce) begin
      v1 <= din_valid;
      op1 <= opcode;
      len1 <= acc_len;
      x1 <= din_1;
      y1 <= din_2;
      w1 <= din_3;
    end
  end
  // MULADD/MULSUB reuse the x*y product structure with w in place of x
  logic use_w;
  d_t u_i, u_q, c1, d1;
  assign use_w = op1 == OP_MULADD || op1 == OP_MULSUB;
  assign u_i = d_t'(use_w ? w1[CW-1:DATA_WIDTH] : x1[CW-1:DATA_WIDTH]);
  assign u_q = d_t'(use_w ? w1[DATA_WIDTH-1:0] : x1[DATA_WIDTH-1:0]);
  assign c1 = d_t'(y1[CW-1:DATA_WIDTH]);
  assign d1 = d_t'(y1[DATA_WIDTH-1:0]);
  logic v2;
  logic [2:0] op2;
  logic [LEN_WIDTH-1:0] len2;
  d_t a2, b2;
  p_t p_ac, p_bd, p_bc, p_ad;
  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else if (ce) begin
      v2 <= v1;
      op2 <= op1;
      len2 <= len1;
      a2 <= d_t'(x1[CW-1:DATA_WIDTH]);
      b2 <= d_t'(x1[DATA_WIDTH-1:0]);
      p_ac <= CW'(u_i) * CW'(c1);
      p_bd <= CW'(u_q) * CW'(d1);
      p_bc <= CW'(u_q) * CW'(c1);
      p_ad <= CW'(u_i) * CW'(d1);
    end
  end
  logic signed [CW:0] sum_i, sum_q;
  acc_t prod_i, prod_q, add_i, add_q, res_i, res_q;
  assign sum_i = (CW+1)'(p_ac) - (CW+1)'(p_bd);
  assign sum_q = (CW+1)'(p_bc) + (CW+1)'(p_ad);
  assign prod_i = acc_t'(sum_i);
  assign prod_q = acc_t'(sum_q);
  // pass-through rides the same path: a<<FRAC rounds back to a exactly
  assign add_i = acc_t'(a2) <<< FRAC_BITS;
  assign add_q = acc_t'(b2) <<< FRAC_BITS;
  assign res_i = op2 == OP_CMULT ? prod_i : op2 == OP_MULADD ? add_i + prod_i :
                 op2 == OP_MULSUB ? add_i - prod_i : add_i;
  assign res_q = op2 == OP_CMULT ? prod_q : op2 == OP_MULADD ? add_q + prod_q :
                 op2 == OP_MULSUB ? add_q - prod_q : add_q;
  acc_t acc_i, acc_q, base_i, base_q, acc_n_i, acc_n_q;
  logic [LEN_WIDTH-1:0] cnt, len_q, len_in, len_eff;
  logic [LEN_WIDTH:0] cnt_p1;
  logic signed [ACC_WIDTH:0] ms_i, ms_q;
  logic is_mac, first, last, ovf_i, ovf_q;
  assign is_mac = op2 == OP_CMAC;
  assign first = cnt == '0;
  assign len_in = len2 == '0 ? LEN_WIDTH'(1) : len2;
  assign len_eff = first ? len_in : len_q;
  assign cnt_p1 = {1'b0, cnt} + (LEN_WIDTH+1)'(1);
  assign last = cnt_p1 >= {1'b0, len_eff};
  assign base_i = first ? '0 : acc_i;
  assign base_q = first ? '0 : acc_q;
  assign ms_i = (ACC_WIDTH+1)'(base_i) + (ACC_WIDTH+1)'(prod_i);
  assign ms_q = (ACC_WIDTH+1)'(base_q) + (ACC_WIDTH+1)'(prod_q);
  assign ovf_i = ms_i[ACC_WIDTH] ^ ms_i[ACC_WIDTH-1];
  assign ovf_q = ms_q[ACC_WIDTH] ^ ms_q[ACC_WIDTH-1];
  assign acc_n_i = ovf_i ? (ms_i[ACC_WIDTH] ? AMIN : AMAX) : ms_i[ACC_WIDTH-1:0];
  assign acc_n_q = ovf_q ? (ms_q[ACC_WIDTH] ? AMIN : AMAX) : ms_q[ACC_WIDTH-1:0];
  logic v3;
  acc_t r3_i, r3_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      acc_i <= '0;
      acc_q <= '0;
      cnt <= '0;
      len_q <= '0;
    end else if (ce) begin
      v3 <= v2 && (!is_mac || last);
      r3_i <= is_mac ? acc_n_i : res_i;
      r3_q <= is_mac ? acc_n_q : res_q;
      if (v2 && is_mac) begin
        acc_i <= last ? '0 : acc_n_i;
        acc_q <= last ? '0 : acc_n_q;
        cnt <= last ? '0 : cnt_p1[LEN_WIDTH-1:0];
        if (first) len_q <= len_in;
      end
    end
  end
  d_t o_i, o_q;
  logic s_i, s_q, sat_set;
  cplx_round_sat #(.IN_W(ACC_WIDTH), .OUT_W(DATA_WIDTH), .FRAC(FRAC_BITS)) u_rs_i (
    .din(r3_i), .dout(o_i), .sat(s_i)
  );
  cplx_round_sat #(.IN_W(ACC_WIDTH), .OUT_W(DATA_WIDTH), .FRAC(FRAC_BITS)) u_rs_q (
    .din(r3_q), .dout(o_q), .sat(s_q)
  );
  assign sat_set = ce && ((v3 && (s_i || s_q)) || (v2 && is_mac && (ovf_i || ovf_q)));
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout <= '0;
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= !sat_clr && (sat_flag || sat_set);
      if (ce) begin
        dout_valid <= v3;
        if (v3) dout <= {o_i, o_q};
      end
    end
  end
endmodule

// File: tb/tb_complex_mac_pipe.sv
// tb_complex_mac_pipe: directed-vector bench for complex_mac_pipe
module tb_complex_mac_pipe;
  import complex_mac_pipe_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] opcode = '0;
  logic [7:0] acc_len = '0;
  logic din_valid = 1'b0, din_ready;
  logic [31:0] din_1 = '0, din_2 = '0, din_3 = '0;
  logic dout_valid, dout_ready = 1'b1;
  logic [31:0] dout;
  logic sat_flag, sat_clr = 1'b0;
  int vecs = 0, errs = 0;
  complex_mac_pipe dut (
    .clk(clk), .rst(rst), .opcode(opcode), .acc_len(acc_len),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic [31:0] w);
    opcode = op;
    din_1 = x;
    din_2 = y;
    din_3 = w;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vecs++; if (din_ready !== 1'b0) begin errs++; $display("FAIL reset_din_ready got %0b want 0", din_ready); end
    vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL reset_dout_valid got %0b want 0", dout_valid); end
    vecs++; if (dout !== 32'h0) begin errs++; $display("FAIL reset_dout got %h want 0", dout); end
    vecs++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL reset_sat_flag got %0b want 0", sat_flag); end
    rst = 1'b0;
    #1;
    vecs++; if (din_ready !== 1'b1) begin errs++; $display("FAIL post_reset_din_ready got %0b want 1", din_ready); end
  endtask
  task automatic test_cmult();
    drive(OP_CMULT, 32'h4000_4000, 32'h4000_C000, 32'h0);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL cmult_early_valid got %0b want 0", dout_valid); end
    step();
    vecs++; if (dout_valid !== 1'b1) begin errs++; $display("FAIL cmult_valid got %0b want 1", dout_valid); end
    vecs++; if (dout !== 32'h4000_0000) begin errs++; $display("FAIL cmult_dout got %h want 40000000", dout); end
    vecs++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL cmult_sat got %0b want 0", sat_flag); end
    step();
    vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL cmult_single_valid got %0b want 0", dout_valid); end
  endtask
  task automatic test_saturate();
    drive(OP_CMULT, 32'h8000_0000, 32'h8000_0000, 32'h0);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    step();
    vecs++; if (dout_valid !== 1'b1) begin errs++; $display("FAIL sat_valid got %0b want 1", dout_valid); end
    vecs++; if (dout !== 32'h7FFF_0000) begin errs++; $display("FAIL sat_dout got %h want 7fff0000", dout); end
    vecs++; if (sat_flag !== 1'b1) begin errs++; $display("FAIL sat_flag_set got %0b want 1", sat_flag); end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    vecs++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL sat_clr got %0b want 0", sat_flag); end
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    vecs++; if (dout !== 32'h7FFF_0000) begin errs++; $display("FAIL sat_prio_dout got %h want 7fff0000", dout); end
    vecs++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL sat_clr_priority got %0b want 0", sat_flag); end
    step();
    vecs++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL sat_clr_after got %0b want 0", sat_flag); end
  endtask
  task automatic test_muladd();
    drive(OP_MULADD, 32'h2000_0000, 32'h4000_0000, 32'h4000_0000);
    din_valid = 1'b1;
    step();
    opcode = OP_MULSUB;
    step();
    din_valid = 1'b0;
    step();
    step();
    vecs++; if (dout_valid !== 1'b1 || dout !== 32'h4000_0000) begin errs++; $display("FAIL muladd got v=%0b %h want v=1 40000000", dout_valid, dout); end
    step();
    vecs++; if (dout_valid !== 1'b1 || dout !== 32'h0000_0000) begin errs++; $display("FAIL mulsub got v=%0b %h want v=1 00000000", dout_valid, dout); end
  endtask
  task automatic test_pass();
    drive(OP_PASS, 32'h1234_ABCD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    din_valid = 1'b1;
    step();
    drive(3'b011, 32'h8000_7FFF, 32'h7FFF_7FFF, 32'h0);
    step();
    din_valid = 1'b0;
    step();
    step();
    vecs++; if (dout_valid !== 1'b1 || dout !== 32'h1234_ABCD) begin errs++; $display("FAIL pass0 got v=%0b %h want v=1 1234abcd", dout_valid, dout); end
    step();
    vecs++; if (dout_valid !== 1'b1 || dout !== 32'h8000_7FFF) begin errs++; $display("FAIL pass3 got v=%0b %h want v=1 80007fff", dout_valid, dout); end
  endtask
  task automatic test_cmac();
    for (int r = 0; r < 2; r++) begin
      int n = 0, at = -1;
      logic [31:0] val = '0;
      acc_len = 8'd4;
      drive(OP_CMAC, 32'h4000_0000, 32'h2000_0000, 32'h0);
      for (int k = 0; k < 12; k++) begin
        din_valid = k < 4;
        step();
        if (dout_valid) begin n++; at = k; val = dout; end
      end
      din_valid = 1'b0;
      vecs++; if (n != 1) begin errs++; $display("FAIL cmac_count run%0d got %0d want 1", r, n); end
      vecs++; if (at != 6) begin errs++; $display("FAIL cmac_latency run%0d got %0d want 6", r, at); end
      vecs++; if (val !== 32'h4000_0000) begin errs++; $display("FAIL cmac_dout run%0d got %h want 40000000", r, val); end
    end
  endtask
  task automatic test_mixed();
    int n = 0;
    int at[4];
    logic [31:0] val[4];
    acc_len = 8'd2;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) drive(OP_CMULT, 32'h4000_4000, 32'h4000_C000, 32'h0);
      else drive(OP_CMAC, 32'h4000_0000, 32'h2000_0000, 32'h0);
      din_valid = k < 3;
      step();
      if (dout_valid && n < 4) begin at[n] = k; val[n] = dout; n++; end
    end
    din_valid = 1'b0;
    vecs++; if (n != 2) begin errs++; $display("FAIL mixed_count got %0d want 2", n); end
    vecs++; if (at[0] != 4 || val[0] !== 32'h4000_0000) begin errs++; $display("FAIL mixed_cmult got k=%0d %h want k=4 40000000", at[0], val[0]); end
    vecs++; if (at[1] != 5 || val[1] !== 32'h2000_0000) begin errs++; $display("FAIL mixed_cmac got k=%0d %h want k=5 20000000", at[1], val[1]); end
  endtask
  task automatic test_back_to_back();
    int sent = 0, rcv = 0;
    logic acc, take, prev_stall = 1'b0;
    logic [31:0] got, prev_dout = '0, exp;
    for (int c = 0; c < 40; c++) begin
      dout_ready = !(c >= 5 && c < 8);
      din_valid = sent < 8;
      drive(OP_CMULT, {16'(16'h0800 * (sent + 1)), 16'h0}, 32'h4000_0000, 32'h0);
      #1;
      if (prev_stall) begin
        vecs++; if (dout !== prev_dout) begin errs++; $display("FAIL bp_hold c%0d got %h want %h", c, dout, prev_dout); end
      end
      if (dout_valid && !dout_ready) begin
        vecs++; if (din_ready !== 1'b0) begin errs++; $display("FAIL bp_din_ready c%0d got %0b want 0", c, din_ready); end
      end
      acc = din_valid && din_ready;
      take = dout_valid && dout_ready;
      got = dout;
      prev_stall = dout_valid && !dout_ready;
      prev_dout = dout;
      step();
      if (acc) sent++;
      if (take) begin
        exp = {16'(16'h0400 * (rcv + 1)), 16'h0};
        vecs++; if (got !== exp) begin errs++; $display("FAIL bp_result%0d got %h want %h", rcv, got, exp); end
        rcv++;
      end
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    vecs++; if (sent != 8) begin errs++; $display("FAIL bp_sent got %0d want 8", sent); end
    vecs++; if (rcv != 8) begin errs++; $display("FAIL bp_received got %0d want 8", rcv); end
  endtask
  task automatic test_rst_mid();
    int n = 0, at = -1;
    logic [31:0] val = '0;
    acc_len = 8'd4;
    drive(OP_CMAC, 32'h4000_0000, 32'h2000_0000, 32'h0);
    din_valid = 1'b1;
    step();
    step();
    din_valid = 1'b0;
    rst = 1'b1;
    step();
    vecs++; if (din_ready !== 1'b0) begin errs++; $display("FAIL rst_mid_din_ready got %0b want 0", din_ready); end
    vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid got %0b want 0", dout_valid); end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (dout_valid) n++;
    end
    vecs++; if (n != 0) begin errs++; $display("FAIL rst_mid_partial got %0d outputs want 0", n); end
    n = 0;
    acc_len = 8'd2;
    drive(OP_CMAC, 32'h4000_0000, 32'h4000_0000, 32'h0);
    for (int k = 0; k < 10; k++) begin
      din_valid = k < 2;
      step();
      if (dout_valid) begin n++; at = k; val = dout; end
    end
    din_valid = 1'b0;
    vecs++; if (n != 1 || at != 4) begin errs++; $display("FAIL rst_fresh_timing got n=%0d k=%0d want n=1 k=4", n, at); end
    vecs++; if (val !== 32'h4000_0000) begin errs++; $display("FAIL rst_fresh_sum got %h want 40000000", val); end
  endtask
  initial begin
    test_reset();
    test_cmult();
    test_saturate();
    test_muladd();
    test_pass();
    test_cmac();
    test_mixed();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
